exe_r_arbiter: RTL and testbench

- Shares one R-type execute unit between NUM_REQ issue requesters.
- Round-robin arbitration feeds the granted operands and instruction to the shared unit, which is combinational and sits outside this block.
- Its result is captured in a single-entry output register with a valid/ready handshake toward writeback.
- Sits between issue/decode ports and the register-file write path.

---
 rtl/exe_r_arbiter_pkg.sv | 17 +
 rtl/exe_r_arbiter_rr_arbiter_comb.sv | 32 +++
 rtl/exe_r_arbiter.sv | 112 +++++++++++
 tb/tb_exe_r_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_r_arbiter_pkg.sv
// Shared constants for the R-type execute arbiter slice: requester limits,
// perf counter width, datapath widths and the packed-slice index helper.
package exe_r_arbiter_pkg;

    localparam int EXE_ARB_MAX_REQ = 4;
    localparam int PERF_CNT_W      = 16;

    localparam int DATA_WIDTH  = 32;
    localparam int RDATA_WIDTH = 32;
    localparam int RADDR_WIDTH = 5;

    // Low bit of requester idx inside a packed per-requester bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/exe_r_arbiter_rr_arbiter_comb.sv
// Combinational round-robin picker: returns the first valid requester at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter_comb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    int cand;

    // Walk offsets from farthest to nearest so the closest valid one wins last.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (valid[cand]) begin
                gnt_idx = ID_W'(cand);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exe_r_arbiter.sv
// Round-robin share of one combinational R-type execute unit with a
// single-entry result register. Define EXE_R_ARB_PERF_EN for perf counters.
module exe_r_arbiter
    import exe_r_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_op1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_op2_i,
    input  logic [NUM_REQ*RDATA_WIDTH-1:0] req_inst_i,
    input  logic [NUM_REQ*RADDR_WIDTH-1:0] req_waddr_i,
    output logic [DATA_WIDTH-1:0]          exe_op1_o,
    output logic [DATA_WIDTH-1:0]          exe_op2_o,
    output logic [RDATA_WIDTH-1:0]         exe_inst_o,
    output logic [RADDR_WIDTH-1:0]         exe_waddr_o,
    input  logic [RDATA_WIDTH-1:0]         exe_wdata_i,
    input  logic                           exe_we_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [RDATA_WIDTH-1:0]         res_wdata_o,
    output logic [RADDR_WIDTH-1:0]         res_waddr_o,
    output logic                           res_we_o,
    output logic [ID_W-1:0]                res_id_o
`ifdef EXE_R_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0]  perf_gnt_cnt_o,
    output logic [PERF_CNT_W-1:0]          perf_stall_cnt_o
`endif
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic            can_accept;
    logic            fire;
    int              gnt_sel;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid   (req_valid_i),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Gating with rst_n_i keeps every ready low while reset is held.
    assign can_accept = !res_valid_o || res_ready_i;
    assign fire       = gnt_any && can_accept && rst_n_i;
    assign gnt_sel    = int'(gnt_idx);
    assign ptr_next   = (gnt_sel == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

    always_comb begin
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = fire;
    end

    assign exe_op1_o   = req_op1_i[slice_lo(gnt_sel, DATA_WIDTH) +: DATA_WIDTH];
    assign exe_op2_o   = req_op2_i[slice_lo(gnt_sel, DATA_WIDTH) +: DATA_WIDTH];
    assign exe_inst_o  = req_inst_i[slice_lo(gnt_sel, RDATA_WIDTH) +: RDATA_WIDTH];
    assign exe_waddr_o = req_waddr_i[slice_lo(gnt_sel, RADDR_WIDTH) +: RADDR_WIDTH];

    // A drain without refill clears only the valid flag; data stays put.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_valid_o <= 1'b0;
            res_wdata_o <= '0;
            res_waddr_o <= '0;
            res_we_o    <= 1'b0;
            res_id_o    <= '0;
            rr_ptr      <= '0;
        end else if (fire) begin
            res_valid_o <= 1'b1;
            res_wdata_o <= exe_wdata_i;
            res_we_o    <= exe_we_i;
            res_waddr_o <= exe_waddr_o;
            res_id_o    <= gnt_idx;
            rr_ptr      <= ptr_next;
        end else if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

`ifdef EXE_R_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_gnt_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire && gnt_sel == i &&
                    perf_gnt_cnt_o[i*PERF_CNT_W +: PERF_CNT_W] != {PERF_CNT_W{1'b1}}) begin
                    perf_gnt_cnt_o[i*PERF_CNT_W +: PERF_CNT_W] <=
                        perf_gnt_cnt_o[i*PERF_CNT_W +: PERF_CNT_W] + PERF_CNT_W'(1);
                end
            end
            if (res_valid_o && !res_ready_i && (|req_valid_i) &&
                perf_stall_cnt_o != {PERF_CNT_W{1'b1}}) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_exe_r_arbiter.sv
// Self-checking bench for exe_r_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_exe_r_arbiter;
    import exe_r_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    logic [DATA_WIDTH-1:0]    op1 [N];
    logic [DATA_WIDTH-1:0]    op2 [N];
    logic [RDATA_WIDTH-1:0]   inst [N];
    logic [RADDR_WIDTH-1:0]   waddr [N];
    logic [N*DATA_WIDTH-1:0]  op1_p, op2_p;
    logic [N*RDATA_WIDTH-1:0] inst_p;
    logic [N*RADDR_WIDTH-1:0] waddr_p;
    logic [DATA_WIDTH-1:0]    exe_op1, exe_op2;
    logic [RDATA_WIDTH-1:0]   exe_inst, exe_wdata;
    logic [RADDR_WIDTH-1:0]   exe_waddr;
    logic                     exe_we;
    logic                     res_valid, res_ready, res_we;
    logic [RDATA_WIDTH-1:0]   res_wdata;
    logic [RADDR_WIDTH-1:0]   res_waddr;
    logic [IW-1:0]            res_id;
`ifdef EXE_R_ARB_PERF_EN
    logic [N*PERF_CNT_W-1:0]  perf_gnt;
    logic [PERF_CNT_W-1:0]    perf_stall;
`endif

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign op1_p[i*DATA_WIDTH +: DATA_WIDTH]     = op1[i];
        assign op2_p[i*DATA_WIDTH +: DATA_WIDTH]     = op2[i];
        assign inst_p[i*RDATA_WIDTH +: RDATA_WIDTH]  = inst[i];
        assign waddr_p[i*RADDR_WIDTH +: RADDR_WIDTH] = waddr[i];
    end

    exe_r_arbiter #(.NUM_REQ(N)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op1_i   (op1_p),
        .req_op2_i   (op2_p),
        .req_inst_i  (inst_p),
        .req_waddr_i (waddr_p),
        .exe_op1_o   (exe_op1),
        .exe_op2_o   (exe_op2),
        .exe_inst_o  (exe_inst),
        .exe_waddr_o (exe_waddr),
        .exe_wdata_i (exe_wdata),
        .exe_we_i    (exe_we),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_wdata_o (res_wdata),
        .res_waddr_o (res_waddr),
        .res_we_o    (res_we),
        .res_id_o    (res_id)
`ifdef EXE_R_ARB_PERF_EN
        ,
        .perf_gnt_cnt_o   (perf_gnt),
        .perf_stall_cnt_o (perf_stall)
`endif
    );

    // Shared execute unit: ADD/SUB/XOR/OR/AND, anything else writes nothing.
    function automatic logic [RDATA_WIDTH:0] alu(input logic [31:0] i, input logic [31:0] a,
                                                 input logic [31:0] b);
        if (i[6:0] != 7'b0110011) return '0;
        case (i[14:12])
            3'b000: begin
                if (i[31:25] == 7'b0000000) return {1'b1, a + b};
                if (i[31:25] == 7'b0100000) return {1'b1, a - b};
                return '0;
            end
            3'b100: return (i[31:25] == 7'd0) ? {1'b1, a ^ b} : '0;
            3'b110: return (i[31:25] == 7'd0) ? {1'b1, a | b} : '0;
            3'b111: return (i[31:25] == 7'd0) ? {1'b1, a & b} : '0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd9, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_inst();
        case ($urandom_range(0, 7))
            0: return mk_r(7'h00, 3'b000);
            1: return mk_r(7'h20, 3'b000);
            2: return mk_r(7'h00, 3'b100);
            3: return mk_r(7'h00, 3'b110);
            4: return mk_r(7'h00, 3'b111);
            5: return mk_r(7'h00, 3'b001);
            6: return {12'd77, 5'd1, 3'b000, 5'd9, 7'b0010011};
            default: return mk_r(7'h01, 3'b000);
        endcase
    endfunction

    always_comb {exe_we, exe_wdata} = alu(exe_inst, exe_op1, exe_op2);

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: result register contents and the round-robin pointer.
    bit                     m_valid;
    logic [RDATA_WIDTH-1:0] m_wdata;
    logic [RADDR_WIDTH-1:0] m_waddr;
    bit                     m_we;
    int                     m_id;
    int                     m_ptr;
    bit                     last_fire;
    int                     last_g;
    int                     m_gcnt [N];
    int                     m_scnt;

    function automatic void model_grant(output int g, output bit any);
        int c;
        any = 1'b0;
        g   = m_ptr;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (req_valid[c]) begin
                g   = c;
                any = 1'b1;
                return;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_update
        int g;
        bit any;
        logic [RDATA_WIDTH:0] r;
        if (!rst_n) begin
            m_valid = 0; m_wdata = '0; m_waddr = '0; m_we = 0; m_id = 0; m_ptr = 0;
            last_fire = 0; last_g = 0; m_scnt = 0;
            for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        end else begin
            model_grant(g, any);
            if (m_valid && !res_ready && (|req_valid) && m_scnt != 16'hFFFF) m_scnt++;
            last_fire = any && (!m_valid || res_ready);
            last_g    = g;
            if (last_fire) begin
                r       = alu(inst[g], op1[g], op2[g]);
                m_valid = 1;
                m_we    = r[RDATA_WIDTH];
                m_wdata = r[RDATA_WIDTH-1:0];
                m_waddr = waddr[g];
                m_id    = g;
                m_ptr   = (g + 1) % N;
                if (m_gcnt[g] != 16'hFFFF) m_gcnt[g]++;
            end else if (m_valid && res_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        bit any;
        logic [N-1:0] exp_rdy;
        if (rst_n) begin
            model_grant(g, any);
            exp_rdy = '0;
            if (any && (!m_valid || res_ready)) exp_rdy[g] = 1'b1;
            checkOutput("cmp_req_ready", 64'(req_ready), 64'(exp_rdy));
            checkOutput("cmp_res_valid", 64'(res_valid), 64'(m_valid));
            checkOutput("cmp_res_wdata", 64'(res_wdata), 64'(m_wdata));
            checkOutput("cmp_res_waddr", 64'(res_waddr), 64'(m_waddr));
            checkOutput("cmp_res_we", 64'(res_we), 64'(m_we));
            checkOutput("cmp_res_id", 64'(res_id), 64'(m_id));
            if (any) begin
                checkOutput("cmp_exe_op1", 64'(exe_op1), 64'(op1[g]));
                checkOutput("cmp_exe_op2", 64'(exe_op2), 64'(op2[g]));
                checkOutput("cmp_exe_inst", 64'(exe_inst), 64'(inst[g]));
                checkOutput("cmp_exe_waddr", 64'(exe_waddr), 64'(waddr[g]));
            end
`ifdef EXE_R_ARB_PERF_EN
            for (int i = 0; i < N; i++)
                checkOutput("cmp_perf_gnt", 64'(perf_gnt[i*PERF_CNT_W +: PERF_CNT_W]), 64'(m_gcnt[i]));
            checkOutput("cmp_perf_stall", 64'(perf_stall), 64'(m_scnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [31:0] i,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wa);
        req_valid[idx] = v;
        inst[idx]      = i;
        op1[idx]       = a;
        op2[idx]       = b;
        waddr[idx]     = wa;
    endtask

    initial begin
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, '0, '0, '0, '0);
        applyStimulus(0, 1'b1, mk_r(7'h00, 3'b000), 32'd1, 32'd1, 5'd1);

        #12;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_res_wdata", 64'(res_wdata), 64'd0);
        checkOutput("rst_res_id", 64'(res_id), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Single ADD from requester 0.
        step();
        applyStimulus(0, 1'b1, mk_r(7'h00, 3'b000), 32'd5, 32'd7, 5'd3);
        @(negedge clk);
        checkOutput("single_ready", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;
        checkOutput("single_valid", 64'(res_valid), 64'd1);
        checkOutput("single_wdata", 64'(res_wdata), 64'd12);
        checkOutput("single_waddr", 64'(res_waddr), 64'd3);
        checkOutput("single_we", 64'(res_we), 64'd1);
        checkOutput("single_id", 64'(res_id), 64'd0);

        // Non-R-type from requester 1 still completes, with no write.
        applyStimulus(1, 1'b1, {12'd5, 5'd1, 3'b000, 5'd4, 7'b0010011}, 32'd9, 32'd9, 5'd4);
        step();
        req_valid = '0;
        checkOutput("nonr_valid", 64'(res_valid), 64'd1);
        checkOutput("nonr_we", 64'(res_we), 64'd0);
        checkOutput("nonr_wdata", 64'(res_wdata), 64'd0);
        checkOutput("nonr_id", 64'(res_id), 64'd1);

        // Contention: grants alternate 0,1,0,1.
        applyStimulus(0, 1'b1, mk_r(7'h00, 3'b000), 32'd100, 32'd1, 5'd10);
        applyStimulus(1, 1'b1, mk_r(7'h00, 3'b111), 32'hF0F0, 32'hFF00, 5'd11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("cont_ready", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            step();
            checkOutput("cont_id", 64'(res_id), 64'(k % 2));
        end
        req_valid = '0;

        // Backpressure: SUB 10-3 held while req1 waits.
        applyStimulus(0, 1'b1, mk_r(7'h20, 3'b000), 32'd10, 32'd3, 5'd6);
        step();
        req_valid = '0;
        res_ready = 1'b0;
        applyStimulus(1, 1'b1, mk_r(7'h00, 3'b000), 32'd1, 32'd2, 5'd7);
        checkOutput("bp_wdata_first", 64'(res_wdata), 64'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_ready_low", 64'(req_ready), 64'd0);
            checkOutput("bp_wdata_hold", 64'(res_wdata), 64'd7);
            checkOutput("bp_valid_hold", 64'(res_valid), 64'd1);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_refire_ready", 64'(req_ready), 64'b10);
        step();
        req_valid = '0;
        checkOutput("bp_refire_id", 64'(res_id), 64'd1);
        checkOutput("bp_refire_wdata", 64'(res_wdata), 64'd3);

        // Async reset mid-stall, pointer left at 1 beforehand.
        applyStimulus(0, 1'b1, mk_r(7'h00, 3'b000), 32'd2, 32'd2, 5'd8);
        step();
        req_valid = '0;
        res_ready = 1'b0;
        checkOutput("ars_valid_before", 64'(res_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ars_valid_drop", 64'(res_valid), 64'd0);
        checkOutput("ars_wdata_clr", 64'(res_wdata), 64'd0);
        req_valid = 2'b11;
        #1;
        checkOutput("ars_ready_low", 64'(req_ready), 64'd0);
        step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("ars_req0_first", 64'(req_ready), 64'b01);
        step();
        checkOutput("ars_id0", 64'(res_id), 64'd0);
        req_valid = '0;

        // Randomized traffic with occasional mid-cycle resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (cyc % 700 == 350) begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rand_rst_valid", 64'(res_valid), 64'd0);
                checkOutput("rand_rst_ready", 64'(req_ready), 64'd0);
                step();
                rst_n = 1'b1;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !(last_fire && last_g == i)) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    applyStimulus(i, ($urandom_range(0, 2) != 0), rand_inst(),
                                  $urandom, $urandom, 5'($urandom));
                end
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
